// File: rtl/cc_pkg.sv
// Shared types and constants for the candy-crush move controller.
// Board geometry, action buffer sizing, direction encoding and the move legality rule.
package cc_pkg;

  localparam int unsigned N_CELLS   = 36;
  localparam int unsigned N_STRIPE  = 4;
  localparam int unsigned ACT_DEPTH = 8;
  localparam int unsigned ACT_W     = 8;
  localparam logic [6:0]  SCORE_MAX = 7'd127;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACT,
    ISSUE,
    WAIT_ENG,
    DONE
  } state_e;

  // Origin must be on the 6x6 board and the swap target must stay on it.
  function automatic logic move_legal(input logic [5:0] pos, input logic [1:0] dir);
    logic [2:0] x;
    logic [2:0] y;
    logic       ok;
    x  = pos[2:0];
    y  = pos[5:3];
    ok = (x <= 3'd5) && (y <= 3'd5);
    case (dir)
      DIR_UP:    ok = ok && (y != 3'd0);
      DIR_DOWN:  ok = ok && (y != 3'd5);
      DIR_LEFT:  ok = ok && (x != 3'd0);
      default:   ok = ok && (x != 3'd5);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cc_act_fifo.sv
// Action buffer: circular FIFO with full/empty flags, simultaneous push/pop
// and a synchronous clear used when a sequence finishes.
module cc_act_fifo import cc_pkg::*; #(
  parameter int unsigned DEPTH = ACT_DEPTH,
  parameter int unsigned WIDTH = ACT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_pop)  rd_d = ptr_inc(rd_q);
      if (do_push) wr_d = ptr_inc(wr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/cc_ctrl.sv
// Move controller: streams the board into the engine, buffers swap actions,
// issues legal moves one at a time and accumulates a saturating score.
module cc_ctrl import cc_pkg::*; #(
  parameter int unsigned N_CELLS   = cc_pkg::N_CELLS,
  parameter int unsigned N_STRIPE  = cc_pkg::N_STRIPE,
  parameter int unsigned ACT_DEPTH = cc_pkg::ACT_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_1,
  input  logic [2:0] in_color,
  input  logic       in_stripe,
  input  logic [5:0] in_starting_pos,
  input  logic       in_valid_2,
  input  logic [1:0] in_action,
  output logic       eng_wr_en,
  output logic [5:0] eng_wr_addr,
  output logic [2:0] eng_wr_color,
  output logic       eng_st_wr,
  output logic [1:0] eng_st_idx,
  output logic [5:0] eng_st_pos,
  output logic       eng_st_type,
  output logic       eng_start,
  output logic [5:0] eng_pos,
  output logic [1:0] eng_dir,
  input  logic       eng_done,
  input  logic [6:0] eng_gain,
  output logic       out_valid,
  output logic [6:0] out_score
);

  localparam int unsigned AW = $clog2(ACT_DEPTH + 1);

  state_e        state_q, state_d;
  logic [5:0]    beat_q, beat_d;
  logic [6:0]    score_q, score_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          seen_q, seen_d;
  logic          pend_q, pend_d;

  logic          f_push, f_pop, f_clr;
  logic          f_full, f_empty;
  logic [7:0]    f_dout;
  logic          head_legal;
  logic          phase_end;
  logic [7:0]    score_sum;

  cc_act_fifo #(
    .DEPTH (ACT_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (f_clr),
    .push_i  (f_push),
    .din_i   ({in_starting_pos, in_action}),
    .pop_i   (f_pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  assign head_legal = move_legal(f_dout[7:2], f_dout[1:0]);
  assign phase_end  = pend_q | (seen_q & ~in_valid_2);
  assign score_sum  = {1'b0, score_q} + {1'b0, eng_gain};

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    score_d      = score_q;
    acnt_d       = acnt_q;
    seen_d       = seen_q;
    pend_d       = pend_q;
    f_push       = 1'b0;
    f_pop        = 1'b0;
    f_clr        = 1'b0;
    eng_wr_en    = 1'b0;
    eng_wr_addr  = '0;
    eng_wr_color = '0;
    eng_st_wr    = 1'b0;
    eng_st_idx   = '0;
    eng_st_pos   = '0;
    eng_st_type  = 1'b0;
    eng_start    = 1'b0;
    eng_pos      = '0;
    eng_dir      = '0;
    out_valid    = 1'b0;
    out_score    = '0;

    // Collection runs alongside issuing; the per-sequence action count is capped,
    // so beats past ACT_DEPTH are dropped even when pops have freed buffer space.
    if ((state_q == ACT || state_q == WAIT_ENG) && !pend_q) begin
      if (in_valid_2) begin
        seen_d = 1'b1;
        if (acnt_q < AW'(ACT_DEPTH) && !f_full) begin
          f_push = 1'b1;
          acnt_d = acnt_q + AW'(1);
        end
      end else if (seen_q) begin
        pend_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, LOAD: begin
        if (in_valid_1) begin
          eng_wr_en    = 1'b1;
          eng_wr_addr  = beat_q;
          eng_wr_color = in_color;
          if (beat_q < 6'(N_STRIPE)) begin
            eng_st_wr   = 1'b1;
            eng_st_idx  = beat_q[1:0];
            eng_st_pos  = in_starting_pos;
            eng_st_type = in_stripe;
          end
          beat_d  = beat_q + 6'd1;
          state_d = (beat_q == 6'(N_CELLS - 1)) ? ACT : LOAD;
        end
      end
      ACT: begin
        if (!f_empty) begin
          f_pop = 1'b1;
          if (head_legal) begin
            eng_start = 1'b1;
            eng_pos   = f_dout[7:2];
            eng_dir   = f_dout[1:0];
            state_d   = WAIT_ENG;
          end else if (phase_end) begin
            state_d = ISSUE;
          end
        end else if (phase_end) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!f_empty) begin
          f_pop = 1'b1;
          if (head_legal) begin
            eng_start = 1'b1;
            eng_pos   = f_dout[7:2];
            eng_dir   = f_dout[1:0];
            state_d   = WAIT_ENG;
          end
        end else begin
          state_d = DONE;
        end
      end
      WAIT_ENG: begin
        if (eng_done) begin
          score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[6:0];
          if (phase_end && f_empty) state_d = DONE;
          else if (phase_end)       state_d = ISSUE;
          else                      state_d = ACT;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_score = score_q;
        f_clr     = 1'b1;
        beat_d    = '0;
        score_d   = '0;
        acnt_d    = '0;
        seen_d    = 1'b0;
        pend_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Load writes follow in_valid_1 combinationally; keep every output quiet in reset.
    if (rst) begin
      eng_wr_en    = 1'b0;
      eng_wr_addr  = '0;
      eng_wr_color = '0;
      eng_st_wr    = 1'b0;
      eng_st_idx   = '0;
      eng_st_pos   = '0;
      eng_st_type  = 1'b0;
      eng_start    = 1'b0;
      eng_pos      = '0;
      eng_dir      = '0;
      out_valid    = 1'b0;
      out_score    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      score_q <= '0;
      acnt_q  <= '0;
      seen_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      score_q <= score_d;
      acnt_q  <= acnt_d;
      seen_q  <= seen_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_cc_ctrl.sv
// Randomised and directed bench for cc_ctrl with a small engine responder and
// a reference model built from the board/move rules.
module tb_cc_ctrl;
  import cc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_1, in_stripe, in_valid_2;
  logic [2:0] in_color;
  logic [5:0] in_starting_pos;
  logic [1:0] in_action;
  logic       eng_wr_en, eng_st_wr, eng_st_type, eng_start, out_valid;
  logic [5:0] eng_wr_addr, eng_st_pos, eng_pos;
  logic [2:0] eng_wr_color;
  logic [1:0] eng_st_idx, eng_dir;
  logic [6:0] out_score;
  logic       eng_done = 1'b0;
  logic [6:0] eng_gain = '0;

  cc_ctrl #(.N_CELLS(36), .N_STRIPE(4), .ACT_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid_1(in_valid_1), .in_color(in_color), .in_stripe(in_stripe),
    .in_starting_pos(in_starting_pos), .in_valid_2(in_valid_2), .in_action(in_action),
    .eng_wr_en(eng_wr_en), .eng_wr_addr(eng_wr_addr), .eng_wr_color(eng_wr_color),
    .eng_st_wr(eng_st_wr), .eng_st_idx(eng_st_idx), .eng_st_pos(eng_st_pos), .eng_st_type(eng_st_type),
    .eng_start(eng_start), .eng_pos(eng_pos), .eng_dir(eng_dir),
    .eng_done(eng_done), .eng_gain(eng_gain),
    .out_valid(out_valid), .out_score(out_score)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] p, input logic [1:0] d);
    int x = int'(p[2:0]);
    int y = int'(p[5:3]);
    if (x > 5 || y > 5) return 1'b0;
    case (d)
      2'd0:    return y != 0;
      2'd1:    return y != 5;
      2'd2:    return x != 0;
      default: return x != 5;
    endcase
  endfunction

  function automatic logic outs_any();
    return |{eng_wr_en, eng_wr_addr, eng_wr_color, eng_st_wr, eng_st_idx, eng_st_pos,
             eng_st_type, eng_start, eng_pos, eng_dir, out_valid, out_score};
  endfunction

  // Engine responder and output capture.
  logic [8:0] wr_log[$];
  logic [8:0] st_log[$];
  logic [7:0] start_log[$];
  logic [6:0] eng_gains[$];
  int         ov_cnt = 0, ov_cyc = 0, last_done_cyc = 0;
  logic [6:0] ov_score = '0;
  bit         eng_busy = 1'b0;
  int         eng_cnt = 0;
  int         eng_delay = -1;
  bit         stray_en = 1'b0;
  logic [6:0] cur_gain = '0;

  always @(negedge clk) begin : mon
    bit real_done;
    real_done = 1'b0;
    eng_done  = 1'b0;
    eng_gain  = '0;
    if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng_done = 1'b1; eng_gain = cur_gain; eng_busy = 1'b0; real_done = 1'b1;
      end else eng_cnt--;
    end else if (stray_en && $urandom_range(7) == 0) begin
      eng_done = 1'b1; eng_gain = 7'($urandom_range(127));
    end
    #2;
    if (real_done) last_done_cyc = cyc;
    if (eng_wr_en) wr_log.push_back({eng_wr_addr, eng_wr_color});
    if (eng_st_wr) st_log.push_back({eng_st_idx, eng_st_pos, eng_st_type});
    if (eng_start) begin
      start_log.push_back({eng_pos, eng_dir});
      eng_busy = 1'b1;
      eng_cnt  = (eng_delay < 0) ? int'($urandom_range(4)) : eng_delay;
      cur_gain = (eng_gains.size() > 0) ? eng_gains.pop_front() : 7'd0;
    end
    if (out_valid) begin
      ov_cnt++; ov_cyc = cyc; ov_score = out_score;
    end else begin
      check_eq("score_idle", 32'(out_score), 32'd0);
    end
  end

  // Sequence description consumed by run_seq.
  logic [2:0] ld_color[40];
  logic [5:0] ld_spos[4];
  logic       ld_stype[4];
  logic [5:0] act_pos[$];
  logic [1:0] act_dir[$];
  logic [6:0] gain_src[$];

  task automatic run_seq(input int n_load, input bit noise);
    logic [8:0] exp_wr[$];
    logic [8:0] exp_st[$];
    logic [7:0] exp_start[$];
    int unsigned sum, exp_score;
    int  acc, k, pe;
    bit  last_legal, got;
    wr_log.delete(); st_log.delete(); start_log.delete();
    ov_cnt = 0;
    eng_gains = gain_src;

    for (int i = 0; i < int'(N_CELLS); i++) exp_wr.push_back({6'(i), ld_color[i]});
    for (int i = 0; i < 4; i++) exp_st.push_back({2'(i), ld_spos[i], ld_stype[i]});
    acc = (act_pos.size() > int'(ACT_DEPTH)) ? int'(ACT_DEPTH) : act_pos.size();
    sum = 0; k = 0; last_legal = 1'b0;
    for (int i = 0; i < acc; i++) begin
      last_legal = legal(act_pos[i], act_dir[i]);
      if (last_legal) begin
        exp_start.push_back({act_pos[i], act_dir[i]});
        sum += (k < gain_src.size()) ? int'(gain_src[k]) : 0;
        k++;
      end
    end
    exp_score = (sum > 127) ? 127 : sum;

    for (int i = 0; i < n_load; i++) begin
      @(negedge clk);
      in_valid_1      = 1'b1;
      in_color        = ld_color[i];
      in_stripe       = (i < 4) ? ld_stype[i] : 1'($urandom);
      in_starting_pos = (i < 4) ? ld_spos[i] : 6'($urandom);
      in_valid_2      = noise && (i < int'(N_CELLS)) && ($urandom_range(3) == 0);
      in_action       = 2'($urandom);
    end
    repeat ($urandom_range(2)) begin
      @(negedge clk);
      in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    end
    for (int i = 0; i < act_pos.size(); i++) begin
      @(negedge clk);
      in_valid_1 = 1'b0; in_valid_2 = 1'b1;
      in_starting_pos = act_pos[i]; in_action = act_dir[i];
    end
    @(negedge clk);
    in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    pe = cyc;

    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk); #3;
      got = (ov_cnt > 0);
    end
    repeat (4) @(negedge clk);
    #3;

    check_eq("ov_seen", 32'(got), 32'd1);
    check_eq("ov_count", 32'(ov_cnt), 32'd1);
    check_eq("ov_score", 32'(ov_score), exp_score);
    check_eq("wr_count", 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      check_eq($sformatf("wr[%0d]", i), 32'(wr_log[i]), 32'(exp_wr[i]));
    check_eq("st_count", 32'(st_log.size()), 32'(exp_st.size()));
    for (int i = 0; i < exp_st.size() && i < st_log.size(); i++)
      check_eq($sformatf("st[%0d]", i), 32'(st_log[i]), 32'(exp_st[i]));
    check_eq("start_count", 32'(start_log.size()), 32'(exp_start.size()));
    for (int i = 0; i < exp_start.size() && i < start_log.size(); i++)
      check_eq($sformatf("start[%0d]", i), 32'(start_log[i]), 32'(exp_start[i]));
    if (k == 0)
      check_eq("lat_illegal", 32'((ov_cyc - pe) <= int'(ACT_DEPTH) + 2), 32'd1);
    else if (last_legal && last_done_cyc >= pe)
      check_eq("lat_done", 32'(ov_cyc), 32'(last_done_cyc + 1));
  endtask

  task automatic directed_board();
    for (int i = 0; i < 40; i++) ld_color[i] = 3'(i % 6);
    ld_spos[0] = 6'd0; ld_spos[1] = 6'd7; ld_spos[2] = 6'd14; ld_spos[3] = 6'd21;
    ld_stype[0] = 1'b0; ld_stype[1] = 1'b1; ld_stype[2] = 1'b0; ld_stype[3] = 1'b1;
  endtask

  task automatic reset_mid_wait();
    bit got;
    wr_log.delete(); st_log.delete(); start_log.delete();
    ov_cnt = 0;
    eng_gains.delete(); eng_gains.push_back(7'd50);
    eng_delay = 8;
    for (int i = 0; i < int'(N_CELLS); i++) begin
      @(negedge clk);
      in_valid_1 = 1'b1; in_color = 3'(i % 6); in_stripe = 1'b0; in_starting_pos = 6'(i);
    end
    @(negedge clk);
    in_valid_1 = 1'b0; in_valid_2 = 1'b1; in_starting_pos = 6'o22; in_action = 2'd3;
    @(negedge clk);
    in_valid_2 = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk); #3;
      got = (start_log.size() > 0);
    end
    check_eq("rst_start_seen", 32'(got), 32'd1);
    @(negedge clk); #4;
    rst = 1'b1;
    #1;
    check_eq("rst_outs_mid", 32'(outs_any()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    eng_delay = -1;
    repeat (20) @(negedge clk);
    #3;
    check_eq("rst_no_restart", 32'(start_log.size()), 32'd1);
    check_eq("rst_no_ov", 32'(ov_cnt), 32'd0);
  endtask

  task automatic rand_seq();
    int n;
    for (int i = 0; i < 40; i++) ld_color[i] = 3'($urandom_range(7));
    for (int i = 0; i < 4; i++) begin
      ld_spos[i] = 6'($urandom); ld_stype[i] = 1'($urandom);
    end
    act_pos.delete(); act_dir.delete(); gain_src.delete();
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1) == 1) act_pos.push_back({3'($urandom_range(5)), 3'($urandom_range(5))});
      else                        act_pos.push_back(6'($urandom));
      act_dir.push_back(2'($urandom));
    end
    for (int i = 0; i < 10; i++) gain_src.push_back(7'($urandom_range(127)));
    stray_en = 1'b1;
    run_seq(($urandom_range(3) == 0) ? 36 + int'($urandom_range(1, 4)) : 36, 1'b1);
    stray_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid_1 = 1'b1; in_valid_2 = 1'b0; in_color = 3'd5; in_stripe = 1'b1;
    in_starting_pos = 6'd9; in_action = 2'd0;
    #1;
    check_eq("rst_outs", 32'(outs_any()), 32'd0);
    @(negedge clk);
    in_valid_1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Board load, stripe table and three in-order legal moves.
    directed_board();
    act_pos = '{6'o11, 6'o23, 6'o44};
    act_dir = '{2'd3, 2'd1, 2'd2};
    gain_src = '{7'd10, 7'd20, 7'd5};
    run_seq(36, 1'b0);

    // Top-row origin swapping up is rejected; only the second move issues.
    act_pos = '{6'o02, 6'o33};
    act_dir = '{2'd0, 2'd0};
    gain_src = '{7'd7};
    run_seq(36, 1'b0);

    // Ten legal actions: only eight accepted, score saturates.
    act_pos.delete(); act_dir.delete(); gain_src.delete();
    for (int i = 0; i < 10; i++) begin
      act_pos.push_back(6'o22); act_dir.push_back(2'(i % 4)); gain_src.push_back(7'd20);
    end
    run_seq(36, 1'b0);

    // Forty load beats: the extra four are ignored.
    directed_board();
    act_pos = '{6'o55};
    act_dir = '{2'd0};
    gain_src = '{7'd3};
    run_seq(40, 1'b0);

    // Abort during an outstanding move, then a fresh sequence scores from zero.
    reset_mid_wait();
    directed_board();
    act_pos = '{6'o10, 6'o45};
    act_dir = '{2'd3, 2'd2};
    gain_src = '{7'd9, 7'd4};
    run_seq(36, 1'b0);

    for (int t = 0; t < 10; t++) rand_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cc_ctrl.md
CC_CTRL -- requirements
Module: cc_ctrl

Interface
REQ-001 Parameters SHALL be: N_CELLS, 36, board cells (6x6 raster); N_STRIPE, 4, striped candies; ACT_DEPTH, 8, action buffer depth.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 in_valid_1  input  1  board-load phase valid; 36 consecutive cycles.
REQ-005 in_color  input  3  candy color, raster order (cell = y*6+x).
REQ-006 in_stripe  input  1  stripe type for load beats 0..3 (0 horizontal, 1 vertical).
REQ-007 in_starting_pos  input  6  {y[5:3], x[2:0]}; stripe position in load beats 0..3, swap origin during in_valid_2.
REQ-008 in_valid_2  input  1  action phase valid; 1..8 consecutive cycles, after load completes.
REQ-009 in_action  input  2  swap direction: 0 up, 1 down, 2 left, 3 right.
REQ-010 eng_wr_en / eng_wr_addr / eng_wr_color  output  1/6/3  board color write to engine.
REQ-011 eng_st_wr / eng_st_idx / eng_st_pos / eng_st_type  output  1/2/6/1  stripe table write.
REQ-012 eng_start / eng_pos / eng_dir  output  1/6/2  one-cycle move command to engine.
REQ-013 eng_done / eng_gain  input  1/7  one-cycle move-complete pulse with points earned.
REQ-014 out_valid / out_score  output  1/7  final result, one-cycle pulse.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, ACT, ISSUE, WAIT_ENG, DONE.
REQ-016 IDLE->LOAD on first in_valid_1 beat; that beat is cell 0 and is written the same cycle (eng_wr_en combinationally follows in_valid_1 in IDLE/LOAD, addr = beat count).
REQ-017 Load beats 0..3 SHALL additionally assert eng_st_wr with eng_st_idx = beat, eng_st_pos = in_starting_pos, eng_st_type = in_stripe.
REQ-018 LOAD->ACT after beat 35; in_valid_1 beats beyond 36, or in_valid_2 before LOAD completes, SHALL be ignored.
REQ-019 Each in_valid_2 beat SHALL push {in_starting_pos, in_action} into the action FIFO; pushes when full (9th+ action) SHALL be dropped.
REQ-020 A move is illegal if x>5, y>5, or target leaves board (y=0 up, y=5 down, x=0 left, x=5 right); illegal moves SHALL be popped with zero gain and no eng_start.
REQ-021 ACT/ISSUE: when FIFO non-empty and no move outstanding, pop head; legal -> assert eng_start one cycle with eng_pos/eng_dir, go WAIT_ENG.
REQ-022 Moves SHALL issue in arrival order; issuing MAY overlap with ongoing in_valid_2 collection.
REQ-023 WAIT_ENG: on eng_done, score <= min(score + eng_gain, 127); eng_done outside WAIT_ENG SHALL be ignored.
REQ-024 Action phase ends at first cycle in_valid_2 is low after it was high; -> DONE when phase ended, FIFO empty, no move outstanding.
REQ-025 DONE: out_valid=1, out_score=score for exactly one cycle, then IDLE with score, counters, FIFO cleared.
REQ-026 out_score SHALL be 0 whenever out_valid is 0; all eng_* strobes 0 when not asserted per above.
REQ-027 Latency: last legal move -> out_valid one cycle after eng_done if phase ended; all-illegal case -> out_valid within ACT_DEPTH+2 cycles of phase end.
REQ-028 Simultaneous push and pop on the FIFO SHALL both take effect; occupancy unchanged.

Reset
REQ-029 rst SHALL asynchronously force IDLE, counters 0, FIFO empty, score 0, all outputs 0.
REQ-030 rst mid-LOAD or mid-WAIT_ENG SHALL abort; no further eng_start, no out_valid until a full new sequence.
REQ-031 Release of rst SHALL take effect on the next rising edge; inputs in that edge are sampled normally.

Structure
REQ-032 Package cc_pkg SHALL hold the state enum, N_CELLS, N_STRIPE, ACT_DEPTH, direction encoding, SCORE_MAX=127.
REQ-033 Sub-module cc_act_fifo (ACT_DEPTH x 8 bit, full/empty, simultaneous push/pop) SHALL hold actions; all else in cc_ctrl.

Verification
REQ-034 36-beat load, colors i%6, stripes at pos 0,7,14,21 types 0,1,0,1 -> 36 writes addr 0..35, 4 stripe writes idx 0..3 matching.
REQ-035 3 legal actions, engine returns gains 10,20,5 -> 3 in-order eng_start, out_valid once with out_score 35.
REQ-036 Action pos {y=0,x=2} dir up plus one legal move gain 7 -> single eng_start, out_score 7.
REQ-037 10 actions, gains 20 each -> 8 issued, 2 dropped, out_score saturates 127.
REQ-038 rst pulse during WAIT_ENG, later eng_done -> no score change, no out_valid; fresh sequence then scores from 0.
REQ-039 40 in_valid_1 beats -> only 36 writes; beats 36..39 ignored.
